// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : 8-digit seven-segment scan controller with frame-synchronous
//                 double-buffered value update and leading-zero suppression.
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        pending,
  output logic        frame_done
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [31:0]        r_disp;
  logic [31:0]        r_shadow;

  logic               w_tick;
  logic               w_boundary;
  logic [2:0]         w_sel_next;
  logic [4:0]         w_shamt;
  logic [31:0]        w_disp_next;
  logic               w_upper_zero;
  logic               w_blank_next;

  assign w_tick     = (r_cnt == c_cnt_max);
  assign w_boundary = w_tick && (sel == 3'd7);
  assign w_sel_next = sel + 3'd1;
  assign w_shamt    = {w_sel_next, 2'b00};

  // A load coinciding with the boundary bypasses the shadow register.
  always_comb begin
    w_disp_next = r_disp;
    if (w_boundary) begin
      if (load) begin
        w_disp_next = data_in;
      end else if (pending) begin
        w_disp_next = r_shadow;
      end
    end
  end

  assign w_upper_zero = ((w_disp_next >> w_shamt) == 32'd0);
  assign w_blank_next = ~digit_en[w_sel_next]
                      | (lz_blank & (w_sel_next != 3'd0) & w_upper_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      sel        <= 3'd0;
      num        <= 4'd0;
      blank      <= 1'b1;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      r_disp     <= 32'd0;
      r_shadow   <= 32'd0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      frame_done <= w_boundary;
      r_disp     <= w_disp_next;

      if (load) begin
        r_shadow <= data_in;
      end

      if (w_boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      if (w_tick) begin
        sel   <= w_sel_next;
        num   <= w_disp_next[w_shamt +: 4];
        blank <= w_blank_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// tb_seg_scan_ctrl : self-checking bench; expected outputs come from a
//                    time-indexed model (slot/frame arithmetic + load log).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  localparam int TD    = 4;
  localparam int FRAME = 8 * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_blank = 1'b0;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        pending;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Model state: edges since reset release, log of sampled loads, and the
  // enables seen at the most recent slot tick.
  int          n = 0;
  int          ld_e[$];
  logic [31:0] ld_d[$];
  logic [7:0]  tick_en = 8'hFF;
  logic        tick_lz = 1'b0;

  logic [9:0] obs;
  assign obs = {sel, num, blank, pending, frame_done};

  seg_scan_ctrl #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Displayed value = last load sampled at or before the latest frame
  // boundary; anything sampled after that boundary is still pending.
  function automatic logic [9:0] model();
    int          b;
    int          s;
    logic [31:0] d;
    logic        p;
    logic        bl;
    logic        fd;
    logic [3:0]  nib;
    b = (n / FRAME) * FRAME;
    d = 32'd0;
    p = 1'b0;
    for (int i = 0; i < ld_e.size(); i++) begin
      if (ld_e[i] <= b) d = ld_d[i];
      else              p = 1'b1;
    end
    s   = (n / TD) % 8;
    nib = d[4*s +: 4];
    if (n < TD) bl = 1'b1;
    else        bl = ~tick_en[s] | (tick_lz && s != 0 && (d >> (4*s)) == 32'd0);
    fd  = (n > 0) && (n % FRAME == 0);
    return {3'(s), nib, bl, p, fd};
  endfunction

  task automatic step(input logic ld, input logic [31:0] d);
    load    = ld;
    data_in = d;
    @(posedge clk);
    if (rst) begin
      n = 0;
      ld_e.delete();
      ld_d.delete();
    end else begin
      n++;
      if (ld) begin
        ld_e.push_back(n);
        ld_d.push_back(d);
      end
      if (n % TD == 0) begin
        tick_en = digit_en;
        tick_lz = lz_blank;
      end
    end
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 32'd0);
    step(1'b0, 32'd0);
    rst = 1'b0;
    checks++;
    if (obs !== 10'b000_0000_1_0_0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", obs, 10'b000_0000_1_0_0);
    end
    // first tick exactly TD cycles after release moves sel to 1
    for (int i = 0; i < TD; i++) step(1'b0, 32'd0);
    checks++;
    if (sel !== 3'd1) begin
      failures++;
      $display("FAIL first_tick sel got=%0d exp=1", sel);
    end
  endtask

  task automatic test_basic();
    int pulses = 0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    step(1'b1, 32'h89ABCDEF);
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b0, 32'd0);
      if (frame_done === 1'b1 && n > FRAME) pulses++;
      checks++;
      if (obs !== model()) begin
        failures++;
        $display("FAIL basic n=%0d got=%h exp=%h", n, obs, model());
      end
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL basic_frame_pulses got=%0d exp=2", pulses);
    end
  endtask

  task automatic test_midframe_load();
    while ((n / TD) % 8 != 3) step(1'b0, 32'd0);
    step(1'b1, 32'h12345678);
    checks++;
    if (pending !== 1'b1 || num !== 4'hC) begin
      failures++;
      $display("FAIL midframe_pending got=%b num=%h exp=1 num=c", pending, num);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 32'd0);
      checks++;
      if (obs !== model()) begin
        failures++;
        $display("FAIL midframe n=%0d got=%h exp=%h", n, obs, model());
      end
    end
  endtask

  task automatic test_boundary_load();
    while (n % FRAME != FRAME - 1) step(1'b0, 32'd0);
    step(1'b1, 32'h00000005);
    checks++;
    if (num !== 4'h5 || sel !== 3'd0 || pending !== 1'b0) begin
      failures++;
      $display("FAIL boundary_bypass got sel=%0d num=%h pend=%b exp sel=0 num=5 pend=0",
               sel, num, pending);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 32'd0);
      checks++;
      if (obs !== model() || pending !== 1'b0) begin
        failures++;
        $display("FAIL boundary n=%0d got=%h exp=%h", n, obs, model());
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [31:0] vals [2];
    vals[0] = 32'h00000012;
    vals[1] = 32'h00000000;
    lz_blank = 1'b1;
    for (int v = 0; v < 2; v++) begin
      step(1'b1, vals[v]);
      for (int i = 0; i < 2 * FRAME; i++) begin
        step(1'b0, 32'd0);
        checks++;
        if (obs !== model()) begin
          failures++;
          $display("FAIL lz_blank v=%h n=%0d got=%h exp=%h", vals[v], n, obs, model());
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_digit_en();
    digit_en = 8'h0F;
    step(1'b1, 32'hFFFFFFFF);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 32'd0);
      checks++;
      if (obs !== model()) begin
        failures++;
        $display("FAIL digit_en n=%0d got=%h exp=%h", n, obs, model());
      end
    end
    digit_en = 8'hFF;
  endtask

  task automatic test_reset_midframe();
    while ((n / TD) % 8 != 5) step(1'b0, 32'd0);
    step(1'b1, 32'hDEADBEEF);
    rst = 1'b1;
    step(1'b0, 32'd0);
    rst = 1'b0;
    checks++;
    if (obs !== 10'b000_0000_1_0_0) begin
      failures++;
      $display("FAIL reset_midframe got=%b exp=%b", obs, 10'b000_0000_1_0_0);
    end
    for (int i = 0; i < FRAME + 2 * TD; i++) begin
      step(1'b0, 32'd0);
      checks++;
      if (obs !== model()) begin
        failures++;
        $display("FAIL after_reset n=%0d got=%h exp=%h", n, obs, model());
      end
    end
  endtask

  task automatic test_random();
    logic        ld;
    logic [31:0] d;
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
      ld = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 1) == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      step(ld, d);
      checks++;
      if (obs !== model()) begin
        failures++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs, model());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_load();
    test_boundary_load();
    test_lz_blank();
    test_digit_en();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds a 32-bit value as eight hex nibbles and steps a digit select through 0..7 at a programmable refresh rate. For each slot it presents the matching nibble (`num`) and the digit index (`sel`) directly to the hex-to-segment/anode decoder stage. New values are double-buffered and applied only at frame boundaries, so a displayed frame is never torn.

## Interface
- `TICK_DIV`, default 100000: clock cycles per digit slot. Minimum 2. At 100 MHz the default gives 1 kHz per digit and 125 Hz per frame.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `data_in`  in  32: value to display. Nibble i (bits 4i+3:4i) drives digit i.
- `load`  in  1: single-cycle strobe that captures `data_in`.
- `digit_en`  in  8: per-digit enable. Bit i = 0 forces digit i blank.
- `lz_blank`  in  1: enables leading-zero suppression.
- `num`  out  4: nibble for the current slot; feeds the decoder `num` input.
- `sel`  out  3: current digit index; feeds the decoder `sel` input.
- `blank`  out  1: 1 = top level forces all anodes off for this slot.
- `pending`  out  1: a loaded value is waiting for the next frame boundary.
- `frame_done`  out  1: one-cycle pulse when `sel` wraps from 7 to 0.

## Operation
- Registers:
  - `cnt`: prescaler, width clog2(TICK_DIV).
  - `sel`.
  - `disp`: 32-bit value being displayed.
  - `shadow`: 32-bit captured value.
  - `pending`.
  - Registered outputs `num`, `blank`, `frame_done`.
- Prescaler:
  - `cnt` counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is true in the cycle where `cnt == TICK_DIV-1`.
- On tick:
  - `sel <= sel + 1`, modulo 8.
  - `num` and `blank` are recomputed for the new `sel`, using the `disp` value in effect after any boundary transfer.
- Frame boundary = tick while `sel == 7`. On a boundary:
  - `frame_done <= 1` for exactly one cycle.
  - If `pending` is set: `disp <= shadow`, `pending <= 0`.
- Load:
  - `load` captures `data_in` into `shadow` and sets `pending <= 1`.
  - A new load while already pending overwrites `shadow`; the last load wins.
- Load in the same cycle as a boundary: bypass. `disp <= data_in` and `pending <= 0`, so the new value appears from slot 0 of the next frame.
- Blank rule for slot i: `blank = ~digit_en[i] | (lz_blank & i != 0 & disp[31:4i] == 0)`.
  - Digit 0 is never suppressed by leading-zero suppression, so a value of 0 still displays "0".
- Between ticks, `num`, `sel` and `blank` hold steady. `digit_en` and `lz_blank` are sampled only at ticks.
- No state machine beyond the counters. Behaviour is fully defined for every input combination.

## Timing
- Reset values:
  - `cnt` = 0, `sel` = 0, `num` = 0.
  - `blank` = 1, `pending` = 0, `frame_done` = 0.
  - `disp` = 0, `shadow` = 0.
- The first tick occurs TICK_DIV cycles after `rst` deasserts, and moves `sel` to 1.
- Each slot lasts exactly TICK_DIV cycles. A frame lasts 8×TICK_DIV cycles.
- `num`, `sel` and `blank` change on the same clock edge. They are never skewed relative to each other.
- Load-to-display latency:
  - Loaded at the boundary cycle: visible in the next slot-0 output.
  - Loaded otherwise: visible at the start of the frame after the current one finishes; worst case 8×TICK_DIV cycles.
- `pending` rises on the edge after `load` and falls on the boundary edge.
- Reset asserted mid-frame: every register returns to its reset value on the next edge. Any pending load is discarded.

## Test plan
1. TICK_DIV=4, `rst`, `digit_en`=FF, `lz_blank`=0, load 32'h89ABCDEF → after the first boundary, `sel` steps 0..7 with each value held 4 cycles; `num` = F,E,D,C,B,A,9,8; `blank`=0; `frame_done` pulses once per 32 cycles.
2. Mid-frame load of 32'h12345678 while 32'h89ABCDEF is displayed → `pending`=1 and `num` keeps following 89ABCDEF until `sel` wraps, then slot 0 shows 8; `pending`=0.
3. Load of 32'h00000005 in the boundary cycle → next slot 0 shows `num`=5; `pending` stays 0 throughout.
4. `lz_blank`=1 with value 32'h00000012 → `blank`=0 for `sel` 0 and 1, `blank`=1 for `sel` 2..7. With value 0 → only `sel`=0 is unblanked, showing `num`=0.
5. `digit_en`=8'h0F with value 32'hFFFFFFFF → `blank`=1 for `sel` 4..7 and 0 for `sel` 0..3; `num`=F in every slot.
6. Assert `rst` at `sel`=5 with `pending`=1 → next cycle `sel`=0, `num`=0, `blank`=1, `pending`=0. After the next boundary the display shows 0, not the discarded value.
